// File: rtl/cpu_decode_pipe.sv
// Single-stage decode pipeline register: decodes R/M/B instructions, reads the register
// file, inserts a load-use bubble, and supports flush. Optional MUL decode via DECODE_MUL_EN.
module cpu_decode_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned IMM_W  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   in_next_pc,
    output logic [REG_AW-1:0] ra_addr,
    output logic [REG_AW-1:0] rb_addr,
    input  logic [XLEN-1:0]   ra_data,
    input  logic [XLEN-1:0]   rb_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        alu_op,
    output logic              use_imm,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              mem_write,
    output logic              branch,
    output logic              illegal,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   ra_val,
    output logic [XLEN-1:0]   rb_val,
    output logic [XLEN-1:0]   imm,
    output logic [XLEN-1:0]   out_next_pc
);

    localparam logic [2:0] CLS_R = 3'b000;
    localparam logic [2:0] CLS_M = 3'b001;
    localparam logic [2:0] CLS_B = 3'b010;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_BEQ   = 4'b0000;
`ifdef DECODE_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'b0010;
`endif

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
`ifdef DECODE_MUL_EN
    localparam logic [1:0] ALU_MUL = 2'b10;
`endif

    logic [2:0]        cls;
    logic [3:0]        sub;
    logic [REG_AW-1:0] rd_field;
    logic [XLEN-1:0]   imm_ext;

    logic [1:0] dec_alu_op;
    logic       dec_use_imm;
    logic       dec_reg_write;
    logic       dec_mem_to_reg;
    logic       dec_mem_write;
    logic       dec_branch;
    logic       dec_illegal;
    logic       dec_uses_rb;

    logic hazard;
    logic load;

    logic              out_valid_q,  out_valid_d;
    logic [1:0]        alu_op_q,     alu_op_d;
    logic              use_imm_q,    use_imm_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              mem_write_q,  mem_write_d;
    logic              branch_q,     branch_d;
    logic              illegal_q,    illegal_d;
    logic [REG_AW-1:0] rd_q,         rd_d;
    logic [XLEN-1:0]   ra_val_q,     ra_val_d;
    logic [XLEN-1:0]   rb_val_q,     rb_val_d;
    logic [XLEN-1:0]   imm_q,        imm_d;
    logic [XLEN-1:0]   next_pc_q,    next_pc_d;

    assign cls      = instr[31:29];
    assign sub      = instr[28:25];
    assign rd_field = REG_AW'(instr[24:20]);
    assign ra_addr  = REG_AW'(instr[19:15]);
    assign rb_addr  = REG_AW'(instr[14:10]);
    assign imm_ext  = {{(XLEN-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

    // Control decode of the incoming instruction; anything unlisted stays illegal with no side effects.
    always_comb begin
        dec_alu_op     = ALU_ADD;
        dec_use_imm    = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_illegal    = 1'b1;
        dec_uses_rb    = 1'b0;
        case (cls)
            CLS_R: begin
                dec_uses_rb = 1'b1;
                case (sub)
                    OP_ADD: begin
                        dec_illegal   = 1'b0;
                        dec_reg_write = 1'b1;
                        dec_alu_op    = ALU_ADD;
                    end
                    OP_SUB: begin
                        dec_illegal   = 1'b0;
                        dec_reg_write = 1'b1;
                        dec_alu_op    = ALU_SUB;
                    end
`ifdef DECODE_MUL_EN
                    OP_MUL: begin
                        dec_illegal   = 1'b0;
                        dec_reg_write = 1'b1;
                        dec_alu_op    = ALU_MUL;
                    end
`endif
                    default: ;
                endcase
            end
            CLS_M: begin
                case (sub)
                    OP_LOAD: begin
                        dec_illegal    = 1'b0;
                        dec_use_imm    = 1'b1;
                        dec_reg_write  = 1'b1;
                        dec_mem_to_reg = 1'b1;
                    end
                    OP_STORE: begin
                        dec_illegal   = 1'b0;
                        dec_use_imm   = 1'b1;
                        dec_mem_write = 1'b1;
                        dec_uses_rb   = 1'b1;
                    end
                    default: ;
                endcase
            end
            CLS_B: begin
                if (sub == OP_BEQ) begin
                    dec_illegal = 1'b0;
                    dec_use_imm = 1'b1;
                    dec_branch  = 1'b1;
                    dec_alu_op  = ALU_SUB;
                    dec_uses_rb = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Load-use hazard: held load writes a register the incoming instruction reads.
    always_comb begin
        hazard = out_valid_q && mem_to_reg_q && (rd_q != '0) &&
                 ((rd_q == ra_addr) || (dec_uses_rb && (rd_q == rb_addr)));
    end

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign load     = in_valid && in_ready;

    // Pipeline register next state: flush, then load, then drain, else hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        alu_op_d     = alu_op_q;
        use_imm_d    = use_imm_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_write_d  = mem_write_q;
        branch_d     = branch_q;
        illegal_d    = illegal_q;
        rd_d         = rd_q;
        ra_val_d     = ra_val_q;
        rb_val_d     = rb_val_q;
        imm_d        = imm_q;
        next_pc_d    = next_pc_q;
        if (flush || (!load && out_ready)) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
            branch_d    = 1'b0;
        end else if (load) begin
            out_valid_d  = 1'b1;
            alu_op_d     = dec_alu_op;
            use_imm_d    = dec_use_imm;
            reg_write_d  = dec_reg_write;
            mem_to_reg_d = dec_mem_to_reg;
            mem_write_d  = dec_mem_write;
            branch_d     = dec_branch;
            illegal_d    = dec_illegal;
            rd_d         = rd_field;
            ra_val_d     = ra_data;
            rb_val_d     = rb_data;
            imm_d        = imm_ext;
            next_pc_d    = in_next_pc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            alu_op_q     <= 2'b00;
            use_imm_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            illegal_q    <= 1'b0;
            rd_q         <= '0;
            ra_val_q     <= '0;
            rb_val_q     <= '0;
            imm_q        <= '0;
            next_pc_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            alu_op_q     <= alu_op_d;
            use_imm_q    <= use_imm_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            illegal_q    <= illegal_d;
            rd_q         <= rd_d;
            ra_val_q     <= ra_val_d;
            rb_val_q     <= rb_val_d;
            imm_q        <= imm_d;
            next_pc_q    <= next_pc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_op      = alu_op_q;
    assign use_imm     = use_imm_q;
    assign reg_write   = reg_write_q;
    assign mem_to_reg  = mem_to_reg_q;
    assign mem_write   = mem_write_q;
    assign branch      = branch_q;
    assign illegal     = illegal_q;
    assign rd          = rd_q;
    assign ra_val      = ra_val_q;
    assign rb_val      = rb_val_q;
    assign imm         = imm_q;
    assign out_next_pc = next_pc_q;

endmodule

// File: tb/tb_cpu_decode_pipe.sv
// Self-checking bench for cpu_decode_pipe: directed vectors plus randomized traffic
// compared cycle by cycle against a table-driven reference model.
module tb_cpu_decode_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] in_next_pc;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [1:0]  alu_op;
    logic        use_imm;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        illegal;
    logic [4:0]  rd;
    logic [31:0] ra_val;
    logic [31:0] rb_val;
    logic [31:0] imm;
    logic [31:0] out_next_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf [32];
    assign ra_data = rf[ra_addr];
    assign rb_data = rf[rb_addr];

    typedef struct packed {
        logic        valid;
        logic [1:0]  alu_op;
        logic        use_imm;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        branch;
        logic        illegal;
        logic [4:0]  rd;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t m;

    cpu_decode_pipe dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_next_pc(in_next_pc),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .alu_op(alu_op), .use_imm(use_imm), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .branch(branch), .illegal(illegal), .rd(rd),
        .ra_val(ra_val), .rb_val(rb_val), .imm(imm), .out_next_pc(out_next_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Reference decode straight from the opcode table: {class, sub-op} -> control bundle.
    function automatic exp_t decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        e         = '0;
        e.valid   = 1'b1;
        e.rd      = i[24:20];
        e.ra      = rf[i[19:15]];
        e.rb      = rf[i[14:10]];
        e.imm     = {{17{i[14]}}, i[14:0]};
        e.pc      = pc;
        e.illegal = 1'b0;
        case (i[31:25])
            7'b000_0000: begin e.alu_op = 2'b00; e.reg_write = 1'b1; end
            7'b000_0001: begin e.alu_op = 2'b01; e.reg_write = 1'b1; end
`ifdef DECODE_MUL_EN
            7'b000_0010: begin e.alu_op = 2'b10; e.reg_write = 1'b1; end
`endif
            7'b001_0000: begin e.use_imm = 1'b1; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            7'b001_0001: begin e.use_imm = 1'b1; e.mem_write = 1'b1; end
            7'b010_0000: begin e.use_imm = 1'b1; e.branch = 1'b1; e.alu_op = 2'b01; end
            default:     e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic compare_outputs();
        check_eq("out_valid",   32'(out_valid),  32'(m.valid));
        check_eq("alu_op",      32'(alu_op),     32'(m.alu_op));
        check_eq("use_imm",     32'(use_imm),    32'(m.use_imm));
        check_eq("reg_write",   32'(reg_write),  32'(m.reg_write));
        check_eq("mem_to_reg",  32'(mem_to_reg), 32'(m.mem_to_reg));
        check_eq("mem_write",   32'(mem_write),  32'(m.mem_write));
        check_eq("branch",      32'(branch),     32'(m.branch));
        check_eq("illegal",     32'(illegal),    32'(m.illegal));
        check_eq("rd",          32'(rd),         32'(m.rd));
        check_eq("ra_val",      ra_val,          m.ra);
        check_eq("rb_val",      rb_val,          m.rb);
        check_eq("imm",         imm,             m.imm);
        check_eq("out_next_pc", out_next_pc,     m.pc);
    endtask

    // One cycle: drive inputs, check handshake/addresses, advance model, check registered outputs.
    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        exp_t nxt;
        logic urb, hz, rdy;
        in_valid   = v;
        instr      = ins;
        in_next_pc = $urandom;
        out_ready  = ordy;
        flush      = fl;
        #2;
        urb = (ins[31:29] == 3'b000) || (ins[31:25] == 7'b010_0000) || (ins[31:25] == 7'b001_0001);
        hz  = m.valid && m.mem_to_reg && (m.rd != 5'd0) &&
              ((m.rd == ins[19:15]) || (urb && (m.rd == ins[14:10])));
        rdy = (!m.valid || ordy) && !hz && !fl;
        check_eq("in_ready", 32'(in_ready), 32'(rdy));
        check_eq("ra_addr",  32'(ra_addr),  32'(ins[19:15]));
        check_eq("rb_addr",  32'(rb_addr),  32'(ins[14:10]));
        nxt = m;
        if (v && rdy) begin
            nxt = decode(ins, in_next_pc);
        end else if (fl || ordy) begin
            nxt.valid     = 1'b0;
            nxt.reg_write = 1'b0;
            nxt.mem_write = 1'b0;
            nxt.branch    = 1'b0;
        end
        @(posedge clock);
        #1;
        m = nxt;
        compare_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [2:0]  c;
        logic [3:0]  s;
        logic [4:0]  rdf, raf, rbf;
        logic [9:0]  lo;
        c   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        s   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 2)) : 4'($urandom);
        rdf = 5'($urandom_range(0, 7));
        raf = 5'($urandom_range(0, 7));
        rbf = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        lo  = 10'($urandom);
        return {c, s, rdf, raf, rbf, lo};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        m          = '0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        instr      = 32'h0;
        in_next_pc = 32'h0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        #3;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        compare_outputs();
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ADD r3,r1,r2
        drive(1'b1, 32'h0030_8800, 1'b1, 1'b0);
        check_eq("add_valid", 32'(out_valid), 32'd1);
        check_eq("add_alu",   32'(alu_op),    32'd0);
        check_eq("add_rd",    32'(rd),        32'd3);
        check_eq("add_ra",    ra_val,         32'd5);
        check_eq("add_rb",    rb_val,         32'd7);
        check_eq("add_rw",    32'(reg_write), 32'd1);

        // LOAD r4 sign-extension boundaries
        drive(1'b1, 32'h2040_FFFF, 1'b1, 1'b0);
        check_eq("ld_imm_neg", imm, 32'hFFFF_FFFF);
        check_eq("ld_m2r",     32'(mem_to_reg), 32'd1);
        check_eq("ld_useimm",  32'(use_imm),    32'd1);
        drive(1'b1, 32'h2040_BFFF, 1'b1, 1'b0);
        check_eq("ld_imm_pos", imm, 32'h0000_3FFF);

        // Load-use bubble: ADD r5,r4,r1 right after LOAD r4
        drive(1'b1, 32'h0052_0400, 1'b1, 1'b0);
        check_eq("bubble_valid", 32'(out_valid), 32'd0);
        check_eq("bubble_rw",    32'(reg_write), 32'd0);
        drive(1'b1, 32'h0052_0400, 1'b1, 1'b0);
        check_eq("post_bubble_valid", 32'(out_valid), 32'd1);
        check_eq("post_bubble_rd",    32'(rd),        32'd5);
        // LOAD to r0 never stalls
        drive(1'b1, 32'h2000_8000, 1'b1, 1'b0);
        drive(1'b1, 32'h0050_0000, 1'b1, 1'b0);
        check_eq("r0_no_bubble", 32'(out_valid), 32'd1);

        // Back-pressure: three stalled cycles then drain
        drive(1'b1, 32'h0231_0800, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b1, 32'h0030_8800, 1'b0, 1'b0);
        check_eq("stall_sub", 32'(alu_op), 32'd1);
        drive(1'b1, 32'h0030_8800, 1'b1, 1'b0);
        check_eq("drain_add", 32'(alu_op), 32'd0);

        // Flush while stalled
        drive(1'b1, 32'h0231_0800, 1'b1, 1'b0);
        drive(1'b1, 32'h0030_8800, 1'b0, 1'b0);
        drive(1'b1, 32'h4000_0C00, 1'b0, 1'b1);
        check_eq("flush_valid",  32'(out_valid), 32'd0);
        check_eq("flush_branch", 32'(branch),    32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("flush_no_issue", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stall
        drive(1'b1, 32'h2060_8000, 1'b1, 1'b0);
        drive(1'b1, 32'h0030_8800, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        m = '0;
        compare_outputs();
        check_eq("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1'b0, 32'h0030_8800, 1'b1, 1'b0);
        check_eq("rst_dropped", 32'(out_valid), 32'd0);

        // Illegal class and the MUL sub-op
        drive(1'b1, 32'hE030_8800, 1'b1, 1'b0);
        check_eq("cls7_illegal", 32'(illegal),   32'd1);
        check_eq("cls7_rw",      32'(reg_write), 32'd0);
        drive(1'b1, 32'h0430_8800, 1'b1, 1'b0);
`ifdef DECODE_MUL_EN
        check_eq("mul_alu",     32'(alu_op),  32'd2);
        check_eq("mul_illegal", 32'(illegal), 32'd0);
`else
        check_eq("mul_illegal", 32'(illegal),   32'd1);
        check_eq("mul_rw",      32'(reg_write), 32'd0);
        check_eq("mul_alu",     32'(alu_op),    32'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_instr(),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_decode_pipe.md
CPU_DECODE_PIPE -- requirements
Module: cpu_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of register data, immediate and PC.
REQ-002 SHALL have parameter REG_AW, default 5, register index width.
REQ-003 SHALL have parameter IMM_W, default 15, raw offset field width, instr[IMM_W-1:0].
REQ-004 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1, instr in 32, in_next_pc in XLEN: fetch-side handshake.
REQ-007 SHALL have ports ra_addr out REG_AW (instr[19:15]), rb_addr out REG_AW (instr[14:10]), ra_data in XLEN, rb_data in XLEN: combinational register-file read.
REQ-008 SHALL have ports out_valid out 1, out_ready in 1: execute-side handshake.
REQ-009 SHALL have registered outputs alu_op 2, use_imm 1, reg_write 1, mem_to_reg 1, mem_write 1, branch 1, illegal 1, rd REG_AW (instr[24:20]), ra_val XLEN, rb_val XLEN, imm XLEN, out_next_pc XLEN.
REQ-010 SHALL have port flush in 1: discard the held and the incoming instruction.

Function
REQ-011 SHALL decode class instr[31:29]: 000 R, 001 M, 010 B; other classes illegal.
REQ-012 R: sub-op instr[28:25] 0000 ADD (alu_op 00), 0001 SUB (01), 0010 MUL (10); reg_write=1, use_imm=0, mem_to_reg=0.
REQ-013 M: instr[28:25] 0000 LOAD (reg_write=1, mem_to_reg=1), 0001 STORE (mem_write=1, reg_write=0); alu_op=00, use_imm=1.
REQ-014 B: instr[28:25] 0000 BEQ; branch=1, alu_op=01, use_imm=1, reg_write=0.
REQ-015 imm SHALL be instr[IMM_W-1:0] sign-extended from bit IMM_W-1 to XLEN bits.
REQ-016 Any undefined class or sub-op SHALL produce illegal=1 with reg_write, mem_write, branch and mem_to_reg all forced to 0.
REQ-017 The pipeline register SHALL load on in_valid && in_ready; latency is one cycle from instr acceptance to out_valid.
REQ-018 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-019 When out_valid && !out_ready, every output SHALL hold stable until accepted.
REQ-020 hazard SHALL be 1 when out_valid, mem_to_reg=1, rd!=0 and rd equals a source index used by the incoming instruction (ra for all classes; rb for R-type, BEQ and STORE).
REQ-021 On hazard with out_ready=1, out_valid SHALL drop to 0 for exactly one cycle (a bubble) and the instruction is accepted the following cycle.
REQ-022 out_valid SHALL clear when out_ready=1 and no new instruction loads.
REQ-023 flush=1 SHALL clear out_valid on the next edge and block acceptance that cycle; flush has priority over load and hazard.
REQ-024 Bubble cycles and flushed entries SHALL force reg_write=0, mem_write=0 and branch=0.

Reset
REQ-025 Reset SHALL asynchronously clear out_valid, reg_write, mem_write, branch, mem_to_reg and illegal to 0, alu_op to 00, and all data/index outputs to 0.
REQ-026 in_ready SHALL be 1 during and immediately after reset.
REQ-027 Reset asserted mid-stall SHALL drop the held instruction with no output transaction.

Configuration
REQ-028 Macro DECODE_MUL_EN: when defined, R sub-op 0010 SHALL decode as MUL (alu_op 10); when undefined, it SHALL be illegal per REQ-016 and alu_op 10 SHALL never be emitted.

Verification
REQ-029 ADD r3,r1,r2 (0x0030_8800), ra_data=5, rb_data=7, out_ready=1 -> next cycle out_valid=1, alu_op=00, rd=3, ra_val=5, rb_val=7, reg_write=1.
REQ-030 LOAD r4 with offset 0x7FFF -> imm=0xFFFF_FFFF, mem_to_reg=1, use_imm=1; offset 0x3FFF -> imm=0x0000_3FFF.
REQ-031 LOAD r4 followed immediately by ADD r5,r4,r1 -> one bubble cycle (out_valid=0, in_ready=0), then ADD issued; a following ADD with rd=0 LOAD causes no bubble.
REQ-032 out_ready=0 for 3 cycles while out_valid=1 -> outputs unchanged, in_ready=0; out_ready=1 -> next instruction loads next edge.
REQ-033 flush=1 while stalled -> out_valid=0 next cycle, the held and incoming instructions are never issued; reset pulse mid-stall -> all outputs 0 immediately.
REQ-034 instr class 111 and R sub-op 0010 -> illegal=1 with all writes 0; with DECODE_MUL_EN defined, sub-op 0010 -> alu_op=10, illegal=0.
